// File: rtl/stopwatch_timer_core.sv
// Up/down MM:SS.hh stopwatch/timer core: programmable prescaler, single-cycle
// BCD carry/borrow chain, clamped preset load, lap capture and event pulses.
module stopwatch_timer_core #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  cnt_ctrl,
    input  logic        dir,
    input  logic        load,
    input  logic [23:0] preset_bcd,
    input  logic        lap,
    input  logic        lap_clear,
    output logic [23:0] time_bcd,
    output logic [23:0] lap_bcd,
    output logic        lap_valid,
    output logic        tick,
    output logic        done,
    output logic        wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 1);
    localparam logic [3:0]    MAX_M1  = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_M0  = 4'(MAX_MIN % 10);
    localparam logic [6:0]    MAX_MIN7 = 7'(MAX_MIN);
    localparam logic [23:0]   MAX_TIME = {MAX_M1, MAX_M0, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   lap_q, lap_d;
    logic          lap_valid_q, lap_valid_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic          tick_int_s;
    mode_e         mode_s;

    // Increment with full carry chain; the caller handles the MAX_TIME wrap.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] m1, m0, s1, s0, t1, t0;
        {m1, m0, s1, s0, t1, t0} = t;
        if (t0 != 4'd9) begin
            t0 = t0 + 4'd1;
        end else begin
            t0 = 4'd0;
            if (t1 != 4'd9) begin
                t1 = t1 + 4'd1;
            end else begin
                t1 = 4'd0;
                if (s0 != 4'd9) begin
                    s0 = s0 + 4'd1;
                end else begin
                    s0 = 4'd0;
                    if (s1 != 4'd5) begin
                        s1 = s1 + 4'd1;
                    end else begin
                        s1 = 4'd0;
                        if (m0 != 4'd9) begin
                            m0 = m0 + 4'd1;
                        end else begin
                            m0 = 4'd0;
                            m1 = m1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {m1, m0, s1, s0, t1, t0};
    endfunction

    // Decrement with full borrow chain; the caller never passes zero.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [3:0] m1, m0, s1, s0, t1, t0;
        {m1, m0, s1, s0, t1, t0} = t;
        if (t0 != 4'd0) begin
            t0 = t0 - 4'd1;
        end else begin
            t0 = 4'd9;
            if (t1 != 4'd0) begin
                t1 = t1 - 4'd1;
            end else begin
                t1 = 4'd9;
                if (s0 != 4'd0) begin
                    s0 = s0 - 4'd1;
                end else begin
                    s0 = 4'd9;
                    if (s1 != 4'd0) begin
                        s1 = s1 - 4'd1;
                    end else begin
                        s1 = 4'd5;
                        if (m0 != 4'd0) begin
                            m0 = m0 - 4'd1;
                        end else begin
                            m0 = 4'd9;
                            m1 = m1 - 4'd1;
                        end
                    end
                end
            end
        end
        return {m1, m0, s1, s0, t1, t0};
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Clamp every nibble to its digit range, then the minute pair to MAX_MIN.
    function automatic logic [23:0] clamp_preset(input logic [23:0] p);
        logic [3:0] m1, m0, s1, s0, t1, t0;
        logic [6:0] mins;
        m1 = clamp_digit(p[23:20], 4'd9);
        m0 = clamp_digit(p[19:16], 4'd9);
        s1 = clamp_digit(p[15:12], 4'd5);
        s0 = clamp_digit(p[11:8],  4'd9);
        t1 = clamp_digit(p[7:4],   4'd9);
        t0 = clamp_digit(p[3:0],   4'd9);
        mins = ({3'd0, m1} * 7'd10) + {3'd0, m0};
        if (mins > MAX_MIN7) begin
            m1 = MAX_M1;
            m0 = MAX_M0;
        end else begin
            m1 = m1;
            m0 = m0;
        end
        return {m1, m0, s1, s0, t1, t0};
    endfunction

    assign mode_s = mode_e'(cnt_ctrl);

    // Next-state: mode decode, prescaler, time update, load and lap handling.
    always_comb begin
        presc_d     = presc_q;
        time_d      = time_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        tick_int_s  = 1'b0;
        case (mode_s)
            MODE_IDLE: begin
                presc_d     = '0;
                time_d      = 24'd0;
                lap_d       = 24'd0;
                lap_valid_d = 1'b0;
            end
            MODE_RUN: begin
                if (presc_q == DIV_M1) begin
                    presc_d    = '0;
                    tick_int_s = 1'b1;
                end else begin
                    presc_d    = presc_q + PW'(1);
                end
                if (tick_int_s) begin
                    if (!dir) begin
                        tick_d = 1'b1;
                        if (time_q == MAX_TIME) begin
                            time_d = 24'd0;
                            wrap_d = 1'b1;
                        end else begin
                            time_d = bcd_inc(time_q);
                        end
                    end else if (time_q != 24'd0) begin
                        time_d = bcd_dec(time_q);
                        tick_d = 1'b1;
                        done_d = (time_d == 24'd0);
                    end else begin
                        time_d = time_q;
                    end
                end else begin
                    time_d = time_q;
                end
            end
            default: begin
                if (load) begin
                    time_d = clamp_preset(preset_bcd);
                end else begin
                    time_d = time_q;
                end
            end
        endcase
        // Lap captures the pre-update time and beats a simultaneous lap_clear.
        if (mode_s != MODE_IDLE) begin
            if (lap) begin
                lap_d       = time_q;
                lap_valid_d = 1'b1;
            end else if (lap_clear) begin
                lap_d       = 24'd0;
                lap_valid_d = 1'b0;
            end else begin
                lap_d       = lap_q;
                lap_valid_d = lap_valid_q;
            end
        end else begin
            lap_d       = 24'd0;
            lap_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            time_q      <= 24'd0;
            lap_q       <= 24'd0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign time_bcd  = time_q;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Scoreboard bench for stopwatch_timer_core at DIV=10, MAX_MIN=59.
module tb_stopwatch_timer_core;

    localparam int F_TIME = 0, F_LAP = 1, F_LV = 2, F_TICK = 3, F_DONE = 4, F_WRAP = 5;
    localparam logic [1:0] C_IDLE = 2'b00, C_RUN = 2'b01, C_PAUSE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cnt_ctrl;
    logic        dir, load, lap, lap_clear;
    logic [23:0] preset_bcd;
    logic [23:0] time_bcd, lap_bcd;
    logic        lap_valid, tick, done, wrap;

    stopwatch_timer_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(59)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_ctrl(cnt_ctrl), .dir(dir), .load(load),
        .preset_bcd(preset_bcd), .lap(lap), .lap_clear(lap_clear),
        .time_bcd(time_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
        .tick(tick), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int tests_run = 0, tests_failed = 0;
    int tick_cnt = 0, wrap_cnt = 0, done_cnt = 0, gap_bad = 0, cyc = 0, last_tick = -1;
    int s_tick, s_wrap, s_done, s_gap;

    // Event monitor: counts pulses and checks tick spacing.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wrap) wrap_cnt <= wrap_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (tick) begin
            tick_cnt  <= tick_cnt + 1;
            last_tick <= cyc;
            if (last_tick >= 0 && (cyc - last_tick) != 10) gap_bad <= gap_bad + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_field(input int sel);
        case (sel)
            F_TIME:  return {8'd0, time_bcd};
            F_LAP:   return {8'd0, lap_bcd};
            F_LV:    return {31'd0, lap_valid};
            F_TICK:  return {31'd0, tick};
            F_DONE:  return {31'd0, done};
            default: return {31'd0, wrap};
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic exp_zero(input string tag);
        exp_push({tag, "_time"}, F_TIME, 32'd0);
        exp_push({tag, "_lap"},  F_LAP,  32'd0);
        exp_push({tag, "_lv"},   F_LV,   32'd0);
        exp_push({tag, "_tick"}, F_TICK, 32'd0);
        exp_push({tag, "_done"}, F_DONE, 32'd0);
        exp_push({tag, "_wrap"}, F_WRAP, 32'd0);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, dut_field(e.sel), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cnt_ctrl = C_IDLE; dir = 1'b0; load = 1'b0;
        lap = 1'b0; lap_clear = 1'b0; preset_bcd = 24'd0;
        step(2);
        exp_zero("reset"); sb_check();
        rst_n = 1'b1;
        step(1);

        // 1: free run up for 10000 cycles
        s_tick = tick_cnt; s_wrap = wrap_cnt; s_done = done_cnt; s_gap = gap_bad;
        cnt_ctrl = C_RUN;
        step(10000);
        exp_push("t1_time", F_TIME, 32'h001000); sb_check();
        check_val("t1_ticks", tick_cnt - s_tick, 32'd1000);
        check_val("t1_gap", gap_bad - s_gap, 32'd0);
        check_val("t1_wrap", wrap_cnt - s_wrap, 32'd0);
        check_val("t1_done", done_cnt - s_done, 32'd0);

        // 2: wrap at maximum
        cnt_ctrl = C_PAUSE; load = 1'b1; preset_bcd = 24'h595999;
        step(1);
        load = 1'b0;
        exp_push("t2_load", F_TIME, 32'h595999); sb_check();
        s_wrap = wrap_cnt;
        cnt_ctrl = C_RUN;
        step(9);
        exp_push("t2_pre", F_TIME, 32'h595999); exp_push("t2_pre_tick", F_TICK, 32'd0); sb_check();
        step(1);
        cnt_ctrl = C_PAUSE;
        exp_push("t2_time", F_TIME, 32'h000000); exp_push("t2_wrap", F_WRAP, 32'd1);
        exp_push("t2_tick", F_TICK, 32'd1); sb_check();
        step(1);
        exp_push("t2_wrap_off", F_WRAP, 32'd0); exp_push("t2_tick_off", F_TICK, 32'd0); sb_check();
        check_val("t2_wrap_cnt", wrap_cnt - s_wrap, 32'd1);

        // 3: count down to zero and hold
        load = 1'b1; preset_bcd = 24'h000003; dir = 1'b1;
        step(1);
        load = 1'b0; cnt_ctrl = C_RUN;
        s_tick = tick_cnt; s_done = done_cnt;
        step(29);
        exp_push("t3_pre", F_TIME, 32'h000001); exp_push("t3_pre_done", F_DONE, 32'd0); sb_check();
        step(1);
        exp_push("t3_zero", F_TIME, 32'h000000); exp_push("t3_done", F_DONE, 32'd1);
        exp_push("t3_tick", F_TICK, 32'd1); sb_check();
        step(50);
        cnt_ctrl = C_PAUSE;
        exp_push("t3_hold", F_TIME, 32'h000000); exp_push("t3_done_off", F_DONE, 32'd0); sb_check();
        check_val("t3_done_cnt", done_cnt - s_done, 32'd1);
        check_val("t3_tick_cnt", tick_cnt - s_tick, 32'd3);

        // borrow through every digit into minutes
        load = 1'b1; preset_bcd = 24'h010000;
        step(1);
        load = 1'b0; cnt_ctrl = C_RUN;
        step(10);
        cnt_ctrl = C_PAUSE;
        exp_push("borrow", F_TIME, 32'h005999); exp_push("borrow_done", F_DONE, 32'd0); sb_check();

        // 4: lap capture, lap+lap_clear, lap_clear
        dir = 1'b0; cnt_ctrl = C_IDLE;
        step(1);
        cnt_ctrl = C_RUN;
        step(1230);
        exp_push("t4_time", F_TIME, 32'h000123); sb_check();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        exp_push("t4_lap", F_LAP, 32'h000123); exp_push("t4_lv", F_LV, 32'd1); sb_check();
        step(9);
        exp_push("t4_cont", F_TIME, 32'h000124); exp_push("t4_lap_kept", F_LAP, 32'h000123); sb_check();
        lap = 1'b1; lap_clear = 1'b1;
        step(1);
        lap = 1'b0; lap_clear = 1'b0;
        exp_push("t4_both_lap", F_LAP, 32'h000124); exp_push("t4_both_lv", F_LV, 32'd1); sb_check();
        lap_clear = 1'b1;
        step(1);
        lap_clear = 1'b0;
        exp_push("t4_clr_lap", F_LAP, 32'd0); exp_push("t4_clr_lv", F_LV, 32'd0); sb_check();

        // 5: pause does not count toward tick spacing
        cnt_ctrl = C_IDLE;
        step(1);
        exp_zero("t5_idle"); sb_check();
        s_tick = tick_cnt;
        cnt_ctrl = C_RUN;   step(7);
        cnt_ctrl = C_PAUSE; step(50);
        check_val("t5_no_tick", tick_cnt - s_tick, 32'd0);
        cnt_ctrl = C_RUN;
        step(2);
        exp_push("t5_tick_pre", F_TICK, 32'd0); sb_check();
        step(1);
        exp_push("t5_tick", F_TICK, 32'd1); exp_push("t5_time", F_TIME, 32'h000001); sb_check();
        check_val("t5_tick_cnt", tick_cnt - s_tick, 32'd1);
        load = 1'b1; preset_bcd = 24'h004500; lap = 1'b1;
        step(1);
        load = 1'b0; lap = 1'b0;
        exp_push("t5_load_ign", F_TIME, 32'h000001); exp_push("t5_lap", F_LAP, 32'h000001);
        exp_push("t5_lv", F_LV, 32'd1); sb_check();
        cnt_ctrl = C_IDLE; load = 1'b1; preset_bcd = 24'h123456; lap = 1'b1;
        step(1);
        load = 1'b0; lap = 1'b0;
        exp_zero("t5_idle2"); sb_check();

        // 6: clamped load, async reset mid-run, restart
        cnt_ctrl = C_PAUSE; load = 1'b1; preset_bcd = 24'h996C9F;
        step(1);
        load = 1'b0;
        exp_push("t6_clamp", F_TIME, 32'h595999); sb_check();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        exp_push("t6_lap", F_LAP, 32'h595999); exp_push("t6_lv", F_LV, 32'd1); sb_check();
        cnt_ctrl = C_RUN;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        exp_zero("t6_async"); sb_check();
        step(1);
        rst_n = 1'b1;
        step(9);
        exp_push("t6_restart_pre", F_TIME, 32'h000000); sb_check();
        step(1);
        exp_push("t6_restart", F_TIME, 32'h000001); exp_push("t6_restart_tick", F_TICK, 32'd1); sb_check();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
